dmemory_param: RTL

DMEMORY_PARAM -- requirements
Module: dmemory_param

---
 rtl/dmemory_param.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmemory_param.sv
// ---------------------------------------------------------------------------
// dmemory_param -- byte-addressable data memory with sub-word load/store.
//
// Purpose:
//   Single-port data memory organised as DEPTH words of DATA_W bits. Stores
//   write only the addressed byte lanes (byte / half / 32-bit word). Loads
//   have one cycle of latency and are sign- or zero-extended to DATA_W.
//   Misaligned or reserved-size accesses are handled in one of two ways,
//   chosen at build time:
//     DMEM_MISALIGN_TRAP_EN defined   : misaligned stores are dropped,
//                                       misaligned loads return 0, and a
//                                       one-cycle misalign pulse plus a
//                                       saturating error counter are active.
//     DMEM_MISALIGN_TRAP_EN undefined : low address bits are forced to the
//                                       access alignment (size 11 behaves as
//                                       a word) and misalign/err_cnt read 0.
//
// Parameters:
//   DATA_W  word width in bits (multiple of 8, at least 32)
//   DEPTH   number of words (power of two)
//   CNT_W   width of the misalign error counter
//
// Ports:
//   clock          in   rising-edge clock
//   rst_n          in   synchronous active-low reset (memory is not cleared)
//   mem_read       in   load request
//   mem_write      in   store request (wins over mem_read)
//   addr[31:0]     in   byte address, wraps modulo memory size
//   size[1:0]      in   00 byte, 01 half, 10 word, 11 reserved
//   load_unsigned  in   1 zero-extends sub-word loads, 0 sign-extends
//   write_data     in   store data, right-justified
//   read_data      out  extended load result, held between loads
//   read_valid     out  read_data valid this cycle
//   misalign       out  previous-cycle access was misaligned / illegal
//   err_cnt        out  saturating count of misaligned / illegal accesses
// ---------------------------------------------------------------------------
module dmemory_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              misalign,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int LANES   = DATA_W / 8;
  localparam int LANE_W  = $clog2(LANES);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int SHIFT_W = LANE_W + 3;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  word_idx;
  logic [LANE_W-1:0] lane_off;
  logic [1:0]        size_eff;
  logic [LANE_W-1:0] low_mask;
  logic [LANE_W-1:0] eff_off;
  logic [LANES-1:0]  base_be;
  logic [LANES-1:0]  byte_en;
  logic [DATA_W-1:0] wdata_sh;

  // Upper address bits are intentionally ignored (address wraps).
  logic unused_addr;
  assign unused_addr = ^addr;

  assign word_idx = addr[IDX_W+LANE_W-1:LANE_W];
  assign lane_off = addr[LANE_W-1:0];

  // Reserved size behaves as a word for data-path purposes.
  assign size_eff = (size == 2'b11) ? 2'b10 : size;

  always_comb begin
    low_mask = '0;
    base_be  = '0;
    case (size_eff)
      2'b00: begin
        low_mask = '0;
        base_be  = LANES'(1);
      end
      2'b01: begin
        low_mask = LANE_W'(1);
        base_be  = LANES'(3);
      end
      default: begin
        // Word access selects a 4-byte lane group even on wider memories.
        low_mask = LANE_W'(3);
        base_be  = LANES'(4'hF);
      end
    endcase
  end

  // Clearing the low offset bits both aligns non-trapping accesses and
  // selects the 4-byte group for word accesses on wide memories.
  assign eff_off  = lane_off & ~low_mask;
  assign byte_en  = base_be << eff_off;
  assign wdata_sh = write_data << SHIFT_W'({eff_off, 3'b000});

  // ---------------------------------------------------------------------
  // Misalignment classification and request enables
  // ---------------------------------------------------------------------
  logic req;
  logic bad_access;
  logic wr_en;
  logic rd_en;
  logic trap_load;

  assign req = mem_read | mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign bad_access = (size == 2'b11)
                    | ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00));
  assign trap_load  = bad_access;
  // Misaligned stores are dropped so memory is left untouched.
  assign wr_en      = rst_n & mem_write & ~bad_access;
`else
  assign bad_access = 1'b0;
  assign trap_load  = 1'b0;
  assign wr_en      = rst_n & mem_write;
`endif

  // A simultaneous store wins; the load is dropped.
  assign rd_en = rst_n & mem_read & ~mem_write;

  // ---------------------------------------------------------------------
  // Storage: one 8-bit RAM per byte lane so each lane has its own write
  // enable and the read port stays a plain registered read.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] ram_q;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clock) begin
        if (wr_en && byte_en[gi]) begin
          lane_mem[word_idx] <= wdata_sh[gi*8 +: 8];
        end
        if (rd_en) begin
          lane_q_reg <= lane_mem[word_idx];
        end
      end

      assign ram_q[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Load-side control registers. These are only updated on an accepted
  // load so read_data holds its value through idle and store cycles.
  // ---------------------------------------------------------------------
  logic              read_valid_reg;
  logic              zero_reg;
  logic [LANE_W-1:0] off_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      read_valid_reg <= 1'b0;
      zero_reg       <= 1'b1;
      off_reg        <= '0;
      size_reg       <= '0;
      uns_reg        <= 1'b0;
    end else begin
      read_valid_reg <= rd_en;
      if (rd_en) begin
        off_reg  <= eff_off;
        size_reg <= size_eff;
        uns_reg  <= load_unsigned;
        zero_reg <= trap_load;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Lane extraction and extension. Size casting of a signed operand
  // sign-extends, which covers every width including DATA_W == 32.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext_data;

  always_comb begin
    shifted  = ram_q >> SHIFT_W'({off_reg, 3'b000});
    ext_data = '0;
    case (size_reg)
      2'b00: begin
        ext_data = uns_reg ? DATA_W'(shifted[7:0])
                           : DATA_W'($signed(shifted[7:0]));
      end
      2'b01: begin
        ext_data = uns_reg ? DATA_W'(shifted[15:0])
                           : DATA_W'($signed(shifted[15:0]));
      end
      default: begin
        ext_data = uns_reg ? DATA_W'(shifted[31:0])
                           : DATA_W'($signed(shifted[31:0]));
      end
    endcase
  end

  assign read_data  = zero_reg ? '0 : ext_data;
  assign read_valid = read_valid_reg;

  // ---------------------------------------------------------------------
  // Misalign pulse and saturating error counter
  // ---------------------------------------------------------------------
`ifdef DMEM_MISALIGN_TRAP_EN
  logic             misalign_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      misalign_reg <= req & bad_access;
      if (req && bad_access && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end
  end

  assign misalign = misalign_reg;
  assign err_cnt  = err_cnt_reg;
`else
  // Nothing observes the classification in this build.
  logic unused_req;
  assign unused_req = req ^ bad_access;

  assign misalign = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule
